// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the 5-stage SIMPLE pipeline: EX/MEM writer history,
// operand forwarding selects, load-use bubble, branch flush and HLT parking.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal issue; forwarding and load-use detection active
// ST_FLUSH | flush held for the remaining cycles after a taken branch
// ST_HALT  | parked after HLT; stall and bubble held until resume
module pipeline_hazard_controller #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       id_valid_i,
    input  logic [1:0] id_op1_i,
    input  logic [2:0] id_op2_i,
    input  logic [2:0] id_cond_i,
    input  logic [3:0] id_op3_i,
    input  logic       ex_branch_taken_i,
    input  logic       resume_i,
    output logic       stall_o,
    output logic       bubble_o,
    output logic       flush_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       halted_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] dest;
        logic       is_load;
    } slot_t;

    localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

    state_e     state_q;
    logic [1:0] cnt_q;
    logic       halted_q;
    slot_t      slot1_q, slot2_q;
    slot_t      slot1_d;
    slot_t      wr_dec;
    logic       a_rd, b_rd;
    logic       hlt_req, load_use;

    always_comb begin
        wr_dec = '0;
        case (id_op1_i)
            2'b11: begin
                wr_dec.valid = (id_op3_i <= 4'b1100) && (id_op3_i != 4'b0101)
                               && (id_op3_i != 4'b0111);
                wr_dec.dest  = id_cond_i;
            end
            2'b10: begin
                wr_dec.valid = (id_op2_i[2:1] == 2'b00);
                wr_dec.dest  = id_cond_i;
            end
            2'b00: begin
                wr_dec.valid   = 1'b1;
                wr_dec.dest    = id_op2_i;
                wr_dec.is_load = 1'b1;
            end
            default: wr_dec = '0;
        endcase
    end

    assign a_rd = ((id_op1_i == 2'b11) && ((id_op3_i <= 4'b0110) || (id_op3_i == 4'b1101)))
                  || (id_op1_i == 2'b01);

    assign b_rd = ((id_op1_i == 2'b11) && ((id_op3_i <= 4'b0101) || (id_op3_i[3:2] == 2'b10)))
                  || (id_op1_i == 2'b01) || (id_op1_i == 2'b00)
                  || ((id_op1_i == 2'b10) && ((id_op2_i == 3'b001) || (id_op2_i == 3'b010)
                                              || (id_op2_i == 3'b110)));

    assign flush_o = ex_branch_taken_i || (state_q == ST_FLUSH);

    assign hlt_req = (state_q == ST_RUN) && !flush_o && id_valid_i
                     && (id_op1_i == 2'b11) && (id_op3_i == 4'b1111);

    assign load_use = id_valid_i && slot1_q.valid && slot1_q.is_load
                      && ((a_rd && (id_op2_i == slot1_q.dest))
                          || (b_rd && (id_cond_i == slot1_q.dest)));

    assign stall_o  = !flush_o && ((state_q == ST_HALT) || load_use);
    assign bubble_o = stall_o;
    assign halted_o = halted_q;

    // A load sitting in EX cannot forward; such a match falls through to MEM.
    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (!flush_o) begin
            if (a_rd && id_valid_i && slot1_q.valid && !slot1_q.is_load
                && (id_op2_i == slot1_q.dest))
                fwd_a_o = 2'b01;
            else if (a_rd && slot2_q.valid && (id_op2_i == slot2_q.dest))
                fwd_a_o = 2'b10;
            if (b_rd && id_valid_i && slot1_q.valid && !slot1_q.is_load
                && (id_cond_i == slot1_q.dest))
                fwd_b_o = 2'b01;
            else if (b_rd && slot2_q.valid && (id_cond_i == slot2_q.dest))
                fwd_b_o = 2'b10;
        end
    end

    assign slot1_d = (id_valid_i && !bubble_o && !flush_o) ? wr_dec : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            slot1_q <= '0;
            slot2_q <= '0;
        end else begin
            slot1_q <= slot1_d;
            slot2_q <= slot1_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_RUN;
            cnt_q    <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken_i) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= (CNT_LOAD == 2'd0) ? ST_RUN : ST_FLUSH;
                    end else if (hlt_req) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // The pulse cycle is the first flush cycle, so leave when the count expires.
                    if (ex_branch_taken_i) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= (CNT_LOAD == 2'd0) ? ST_RUN : ST_FLUSH;
                    end else if (cnt_q <= 2'd1) begin
                        cnt_q   <= 2'd0;
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_HALT: begin
                    if (resume_i) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    cnt_q    <= 2'd0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed hazard sequences then
// random instruction streams, checked against a behavioural pipeline model.
module tb_pipeline_hazard_controller;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [1:0] id_op1 = '0;
    logic [2:0] id_op2 = '0;
    logic [2:0] id_cond = '0;
    logic [3:0] id_op3 = '0;
    logic       br = 1'b0;
    logic       resume = 1'b0;
    logic       stall, bubble, flush, halted;
    logic [1:0] fwd_a, fwd_b;

    pipeline_hazard_controller #(.FLUSH_CYCLES(FC)) dut (
        .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .id_op1_i(id_op1),
        .id_op2_i(id_op2), .id_cond_i(id_cond), .id_op3_i(id_op3),
        .ex_branch_taken_i(br), .resume_i(resume), .stall_o(stall), .bubble_o(bubble),
        .flush_o(flush), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .halted_o(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit [1:0] fa, fb;
        bit       st, bb, fl, hl;
    } exp_t;

    typedef struct packed {
        bit       v;
        bit [2:0] d;
        bit       ld;
    } rec_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Model: hist[0] = instruction now in EX, hist[1] = now in MEM.
    rec_t hist[2];
    int   flush_left = 0;
    bit   m_halt = 0;
    rec_t p_rec;
    bit   p_rst = 1, p_issue = 0, p_br = 0, p_res = 0, p_hlt = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    function automatic rec_t writes(bit [1:0] o1, bit [2:0] o2, bit [2:0] c, bit [3:0] o3);
        rec_t r = '0;
        if (o1 == 2'd3 && o3 inside {[0:12]} && !(o3 inside {5, 7})) r = '{v: 1, d: c, ld: 0};
        else if (o1 == 2'd2 && o2 inside {0, 1})                     r = '{v: 1, d: c, ld: 0};
        else if (o1 == 2'd0)                                          r = '{v: 1, d: o2, ld: 1};
        return r;
    endfunction

    function automatic bit reads_a(bit [1:0] o1, bit [3:0] o3);
        return (o1 == 2'd3 && (o3 inside {[0:6], 13})) || o1 == 2'd1;
    endfunction

    function automatic bit reads_b(bit [1:0] o1, bit [2:0] o2, bit [3:0] o3);
        return (o1 == 2'd3 && (o3 inside {[0:5], [8:11]})) || o1 inside {0, 1}
               || (o1 == 2'd2 && o2 inside {1, 2, 6});
    endfunction

    function automatic bit [1:0] sel(bit rd, bit v, bit [2:0] r);
        if (rd && v && hist[0].v && !hist[0].ld && hist[0].d == r) return 2'd1;
        if (rd && hist[1].v && hist[1].d == r) return 2'd2;
        return 2'd0;
    endfunction

    task automatic cycle(input bit r, input bit v, input bit [1:0] o1, input bit [2:0] o2,
                         input bit [2:0] c, input bit [3:0] o3, input bit b, input bit rs);
        exp_t e;
        bit   fl, lu, bub;
        rec_t w;
        @(posedge clk);
        #1;
        if (!p_rst) begin
            hist[1] = hist[0];
            hist[0] = p_issue ? p_rec : '0;
            if (p_br) flush_left = FC - 1;
            else if (flush_left > 0) flush_left--;
            if (m_halt && p_res) m_halt = 0;
            else if (p_hlt) m_halt = 1;
        end
        b = b && !m_halt;
        reset = r; id_valid = v; id_op1 = o1; id_op2 = o2; id_cond = c; id_op3 = o3;
        br = b; resume = rs;
        if (r) begin
            hist[0] = '0; hist[1] = '0; flush_left = 0; m_halt = 0;
        end
        w   = writes(o1, o2, c, o3);
        fl  = b || flush_left > 0;
        lu  = v && hist[0].v && hist[0].ld
              && ((reads_a(o1, o3) && o2 == hist[0].d) || (reads_b(o1, o2, o3) && c == hist[0].d));
        bub = !fl && (m_halt || lu);
        e.fl = fl;
        e.st = bub;
        e.bb = bub;
        e.hl = m_halt;
        e.fa = fl ? 2'd0 : sel(reads_a(o1, o3), v, o2);
        e.fb = fl ? 2'd0 : sel(reads_b(o1, o2, o3), v, c);
        p_rst   = r;
        p_rec   = w;
        p_issue = v && !bub && !fl && w.v;
        p_br    = b;
        p_res   = rs;
        p_hlt   = v && !fl && !m_halt && o1 == 2'd3 && o3 == 4'hF;
        sbq.push_back(e);
    endtask

    task automatic ins(input bit [1:0] o1, input bit [2:0] o2, input bit [2:0] c, input bit [3:0] o3);
        cycle(0, 1, o1, o2, c, o3, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stall", stall, e.st);
                chk("bubble", bubble, e.bb);
                chk("flush", flush, e.fl);
                chk("fwd_a", fwd_a, e.fa);
                chk("fwd_b", fwd_b, e.fb);
                chk("halted", halted, e.hl);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        hist[0] = '0;
        hist[1] = '0;
        p_rec   = '0;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // EX then MEM forwarding of r3
        ins(2'd3, 3'd1, 3'd3, 4'h0);
        ins(2'd3, 3'd4, 3'd3, 4'h5);
        ins(2'd3, 3'd0, 3'd3, 4'h5);
        idle(2);
        // load-use on r5: bubble, then MEM forward
        ins(2'd0, 3'd5, 3'd1, 4'h0);
        ins(2'd3, 3'd5, 3'd2, 4'h0);
        ins(2'd3, 3'd5, 3'd2, 4'h0);
        idle(2);
        // two writers of r2, EX wins
        ins(2'd3, 3'd0, 3'd2, 4'h0);
        ins(2'd3, 3'd1, 3'd2, 4'h1);
        ins(2'd3, 3'd2, 3'd0, 4'h5);
        idle(2);
        // branch with coincident load-use, then reload during flush
        ins(2'd0, 3'd6, 3'd0, 4'h0);
        cycle(0, 1, 2'd3, 3'd6, 3'd1, 4'h5, 1, 0);
        ins(2'd3, 3'd6, 3'd6, 4'h5);
        ins(2'd3, 3'd6, 3'd6, 4'h5);
        cycle(0, 1, 2'd3, 3'd1, 3'd1, 4'h0, 1, 0);
        cycle(0, 1, 2'd3, 3'd1, 3'd1, 4'h0, 1, 0);
        ins(2'd3, 3'd1, 3'd1, 4'h5);
        idle(3);
        // HLT held for 10 cycles, then resume
        ins(2'd3, 3'd0, 3'd0, 4'hF);
        for (int i = 0; i < 10; i++) ins(2'd3, 3'd2, 3'd3, 4'h0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // reset during FLUSH, then CMP + reader
        cycle(0, 1, 2'd3, 3'd1, 3'd2, 4'h0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        ins(2'd3, 3'd1, 3'd2, 4'h5);
        ins(2'd3, 3'd2, 3'd2, 4'h5);
        // reset during HALT
        ins(2'd3, 3'd0, 3'd0, 4'hF);
        idle(3);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            bit lo = $urandom_range(0, 1) == 1;
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)),
                  3'(lo ? $urandom_range(0, 2) : $urandom_range(0, 7)),
                  3'(lo ? $urandom_range(0, 2) : $urandom_range(0, 7)),
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
